voice_scheduler: RTL

- Polyphonic voice controller between the PS/2 keyboard decoder and the audio output path.
- Keeps a table of held notes (voices) from key make/break events.
- Time-multiplexes one shared waveform generator across the active voices: presents one note, waits for its sample, then accumulates.
- Writes each mixed sample to the Audio Controller's left/right output using the audio_out_allowed / write handshake.

---
 rtl/voice_scheduler_pkg.sv | 34 +++
 rtl/voice_scheduler_table.sv | 119 +++++++++++
 rtl/voice_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/voice_scheduler_pkg.sv
// Shared definitions for the voice scheduler: FSM state encodings, the
// voice record layout, the sample width and a saturating age helper.
// No ports (package).
package voice_scheduler_pkg;

  localparam int SAMPLE_W = 32;
  localparam int NOTE_W   = 5;
  localparam int AGE_W    = 4;
  localparam logic [AGE_W-1:0] AGE_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_REQ   = 3'd2,
    S_ACC   = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] note;
    logic [AGE_W-1:0]  age;
  } voice_t;

  // Age increment that sticks at AGE_MAX.
  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
    if (age == AGE_MAX) begin
      return AGE_MAX;
    end else begin
      return age + 4'd1;
    end
  endfunction

endpackage

// File: rtl/voice_scheduler_table.sv
// voice_table: held-note table for the voice scheduler.
// Key events are registered, then applied one cycle later: press retriggers
// a matching voice, else allocates the lowest free voice, else steals the
// oldest voice (ties to the lowest index). Release clears every match.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   key_valid/note/press  key event strobe, note code, 1=make 0=break
//   active_mask           bit i = voice i holds a note
//   notes                 note code held by each voice
module voice_table
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 key_valid,
  input  logic [NOTE_W-1:0]                    key_note,
  input  logic                                 key_press,
  output logic [NUM_VOICES-1:0]                active_mask,
  output logic [NUM_VOICES-1:0][NOTE_W-1:0]    notes
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  voice_t [NUM_VOICES-1:0] voices_r;
  voice_t [NUM_VOICES-1:0] voices_s;
  logic                    ev_valid_r;
  logic                    ev_press_r;
  logic [NOTE_W-1:0]       ev_note_r;
  logic [NUM_VOICES-1:0]   hit_s;
  logic                    free_found_s;
  logic [IDX_W-1:0]        free_idx_s;
  logic [IDX_W-1:0]        steal_idx_s;
  logic [AGE_W-1:0]        steal_age_s;
  logic [IDX_W-1:0]        target_s;

  // Match the pending event against the table, find first free and oldest voice.
  always_comb begin
    hit_s        = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    steal_idx_s  = '0;
    steal_age_s  = voices_r[0].age;
    for (int i = 0; i < NUM_VOICES; i++) begin
      hit_s[i] = voices_r[i].active && (voices_r[i].note == ev_note_r);
      if (!voices_r[i].active && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
      // Strictly-greater keeps the lowest index on equal ages.
      if (voices_r[i].age > steal_age_s) begin
        steal_age_s = voices_r[i].age;
        steal_idx_s = IDX_W'(i);
      end else begin
        steal_age_s = steal_age_s;
      end
    end
  end

  // Next table contents for the registered key event.
  always_comb begin
    voices_s = voices_r;
    target_s = free_found_s ? free_idx_s : steal_idx_s;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!ev_valid_r) begin
        voices_s[i] = voices_r[i];
      end else if (!ev_press_r) begin
        if (hit_s[i]) begin
          voices_s[i] = '0;
        end else begin
          voices_s[i] = voices_r[i];
        end
      end else if (|hit_s) begin
        if (hit_s[i]) begin
          voices_s[i].age = '0;
        end else if (voices_r[i].active) begin
          voices_s[i].age = age_inc(voices_r[i].age);
        end else begin
          voices_s[i] = voices_r[i];
        end
      end else if (IDX_W'(i) == target_s) begin
        voices_s[i] = {1'b1, ev_note_r, {AGE_W{1'b0}}};
      end else if (voices_r[i].active) begin
        voices_s[i].age = age_inc(voices_r[i].age);
      end else begin
        voices_s[i] = voices_r[i];
      end
    end
  end

  // Event capture and table state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_r <= 1'b0;
      ev_press_r <= 1'b0;
      ev_note_r  <= '0;
      voices_r   <= '0;
    end else begin
      ev_valid_r <= key_valid;
      ev_press_r <= key_press;
      ev_note_r  <= key_note;
      voices_r   <= voices_s;
    end
  end

  // Export the active bits and notes straight from the table registers.
  always_comb begin
    active_mask = '0;
    notes       = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      active_mask[i] = voices_r[i].active;
      notes[i]       = voices_r[i].note;
    end
  end

endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: polyphonic voice controller. Visits each active voice in
// turn, requests one sample from the shared waveform generator, sums the
// samples and writes the shifted mix to the audio output FIFO.
// Optional macro VOICE_SCHEDULER_SAT_EN: when defined the shifted sum
// saturates to 32-bit signed; otherwise its low 32 bits are taken.
// Ports:
//   CLOCK_50, reset          clock, asynchronous active-high reset
//   key_valid/note/press     key event from the keyboard decoder
//   voice_note, voice_req    note and request to the waveform generator
//   voice_sample, sample_valid  returned sample and its strobe
//   audio_out_allowed        output FIFO has space
//   write_audio_out          one-cycle write strobe
//   audio_mix                mixed sample for both channels
//   active_mask              voices holding a note
//   busy                     mix FSM not idle
module voice_scheduler
  import voice_scheduler_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int MIX_SHIFT   = 2,
  parameter int REQ_TIMEOUT = 255
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [NOTE_W-1:0]     key_note,
  input  logic                  key_press,
  output logic [NOTE_W-1:0]     voice_note,
  output logic                  voice_req,
  input  logic [SAMPLE_W-1:0]   voice_sample,
  input  logic                  sample_valid,
  input  logic                  audio_out_allowed,
  output logic                  write_audio_out,
  output logic [SAMPLE_W-1:0]   audio_mix,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + IDX_W;
  localparam int TMR_W = $clog2(REQ_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REQ_TIMEOUT - 1);

  logic [NUM_VOICES-1:0][NOTE_W-1:0] notes_s;

  state_t                    state_r, state_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic signed [ACC_W-1:0]   acc_r, acc_s;
  logic [SAMPLE_W-1:0]       sample_r, sample_s;
  logic [TMR_W-1:0]          timer_r, timer_s;
  logic [NOTE_W-1:0]         note_r, note_s;
  logic                      req_r, req_s;
  logic                      write_r, write_s;
  logic [SAMPLE_W-1:0]       mix_r, mix_s;

  // Scale the accumulated sum back to one output sample.
  function automatic logic [SAMPLE_W-1:0] reduce_mix(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> MIX_SHIFT;
`ifdef VOICE_SCHEDULER_SAT_EN
    // In range only when every bit above the 32-bit sign bit copies it.
    if ((&shifted[ACC_W-1:SAMPLE_W-1]) || !(|shifted[ACC_W-1:SAMPLE_W-1])) begin
      return shifted[SAMPLE_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      return 32'h8000_0000;
    end else begin
      return 32'h7FFF_FFFF;
    end
`else
    return shifted[SAMPLE_W-1:0];
`endif
  endfunction

  voice_table #(.NUM_VOICES(NUM_VOICES)) u_table (
    .clk         (CLOCK_50),
    .rst         (reset),
    .key_valid   (key_valid),
    .key_note    (key_note),
    .key_press   (key_press),
    .active_mask (active_mask),
    .notes       (notes_s)
  );

  // Mix FSM next state and datapath updates.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    acc_s    = acc_r;
    sample_s = sample_r;
    timer_s  = timer_r;
    note_s   = note_r;
    mix_s    = mix_r;
    write_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (audio_out_allowed) begin
          acc_s   = '0;
          idx_s   = '0;
          state_s = S_SCAN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SCAN: begin
        // The voice is sampled as it stands right now.
        if (active_mask[idx_r]) begin
          note_s  = notes_s[idx_r];
          timer_s = '0;
          state_s = S_REQ;
        end else if (idx_r == LAST_IDX) begin
          state_s = S_WRITE;
        end else begin
          idx_s = idx_r + 1'b1;
        end
      end
      S_REQ: begin
        if (sample_valid) begin
          sample_s = voice_sample;
          state_s  = S_ACC;
        end else if (timer_r == TMR_LAST) begin
          sample_s = '0;
          state_s  = S_ACC;
        end else begin
          timer_s = timer_r + 1'b1;
        end
      end
      S_ACC: begin
        acc_s = acc_r + $signed({{IDX_W{sample_r[SAMPLE_W-1]}}, sample_r});
        if (idx_r == LAST_IDX) begin
          state_s = S_WRITE;
        end else begin
          idx_s   = idx_r + 1'b1;
          state_s = S_SCAN;
        end
      end
      S_WRITE: begin
        if (audio_out_allowed) begin
          mix_s   = reduce_mix(acc_r);
          write_s = 1'b1;
          state_s = S_IDLE;
        end else begin
          state_s = S_WRITE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    req_s = (state_s == S_REQ);
  end

  // FSM, datapath and registered output stage.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r  <= S_IDLE;
      idx_r    <= '0;
      acc_r    <= '0;
      sample_r <= '0;
      timer_r  <= '0;
      note_r   <= '0;
      req_r    <= 1'b0;
      write_r  <= 1'b0;
      mix_r    <= '0;
    end else begin
      state_r  <= state_s;
      idx_r    <= idx_s;
      acc_r    <= acc_s;
      sample_r <= sample_s;
      timer_r  <= timer_s;
      note_r   <= note_s;
      req_r    <= req_s;
      write_r  <= write_s;
      mix_r    <= mix_s;
    end
  end

  assign voice_note      = note_r;
  assign voice_req       = req_r;
  assign write_audio_out = write_r;
  assign audio_mix       = mix_r;
  assign busy            = (state_r != S_IDLE);

endmodule
